// File: rtl/toy_sequencer.sv
// ============================================================================
// Module   : toy_sequencer
// Brief    : Multi-cycle FETCH/DECODE/MEM/EXEC control sequencer with
//            ready handshake and wait timeout for the toy accumulator CPU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module toy_sequencer #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [3:0] opcode,
    input  logic       mem_ready,
    input  logic       carry,
    input  logic       zero,
    output logic       imem_rd,
    output logic       ir_ld,
    output logic [1:0] src_pc,
    output logic [2:0] alu_op,
    output logic       wr_t,
    output logic       wr_a,
    output logic       src_a,
    output logic       wr_dmem,
    output logic       rd_dmem,
    output logic       src_adr,
    output logic       src_data,
    output logic       halted,
    output logic       fault
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_MEM    = 3'd3,
        S_EXEC   = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [7:0] c_wait_limit = 8'(TIMEOUT - 1);

    localparam logic [3:0] c_op_jmp = 4'b0000;
    localparam logic [3:0] c_op_adc = 4'b0001;
    localparam logic [3:0] c_op_xor = 4'b0010;
    localparam logic [3:0] c_op_sbr = 4'b0011;
    localparam logic [3:0] c_op_ror = 4'b0100;
    localparam logic [3:0] c_op_tat = 4'b0101;
    localparam logic [3:0] c_op_or  = 4'b0110;
    localparam logic [3:0] c_op_hlt = 4'b0111;
    localparam logic [3:0] c_op_and = 4'b1000;
    localparam logic [3:0] c_op_ldc = 4'b1001;
    localparam logic [3:0] c_op_bcc = 4'b1010;
    localparam logic [3:0] c_op_bne = 4'b1011;
    localparam logic [3:0] c_op_ldi = 4'b1100;
    localparam logic [3:0] c_op_stt = 4'b1101;
    localparam logic [3:0] c_op_lda = 4'b1110;
    localparam logic [3:0] c_op_sta = 4'b1111;

    localparam logic [1:0] c_pc_inc  = 2'b00;
    localparam logic [1:0] c_pc_vec  = 2'b01;
    localparam logic [1:0] c_pc_hold = 2'b10;

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_wait_cnt;
    logic       r_fault;
    logic       w_timeout;
    logic       w_is_rd;
    logic       w_is_wr;
    logic       w_waiting;

    always_comb begin
        w_is_rd = 1'b0;
        w_is_wr = 1'b0;
        case (opcode)
            c_op_adc, c_op_xor, c_op_sbr, c_op_or,
            c_op_and, c_op_ldc, c_op_lda, c_op_ldi: w_is_rd = 1'b1;
            c_op_stt, c_op_sta:                     w_is_wr = 1'b1;
            default: ;
        endcase
    end

    assign w_waiting = ((r_state == S_FETCH) || (r_state == S_MEM)) && !mem_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= 8'd0;
            r_fault    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            // Any state change restarts the count, so FETCH/MEM always start at 0.
            if (w_state_next != r_state)
                r_wait_cnt <= 8'd0;
            else if (w_waiting)
                r_wait_cnt <= r_wait_cnt + 8'd1;
            if (w_timeout)
                r_fault <= 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_timeout    = 1'b0;
        imem_rd      = 1'b0;
        ir_ld        = 1'b0;
        src_pc       = c_pc_hold;
        alu_op       = 3'b000;
        wr_t         = 1'b0;
        wr_a         = 1'b0;
        src_a        = 1'b0;
        wr_dmem      = 1'b0;
        rd_dmem      = 1'b0;
        src_adr      = 1'b0;
        src_data     = 1'b0;
        halted       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (run)
                    w_state_next = S_FETCH;
            end
            S_FETCH: begin
                imem_rd = 1'b1;
                if (mem_ready) begin
                    ir_ld        = 1'b1;
                    w_state_next = S_DECODE;
                end else if (r_wait_cnt == c_wait_limit) begin
                    w_timeout    = 1'b1;
                    w_state_next = S_HALT;
                end
            end
            S_DECODE: begin
                if (opcode == c_op_hlt)
                    w_state_next = S_HALT;
                else if (w_is_rd || w_is_wr)
                    w_state_next = S_MEM;
                else
                    w_state_next = S_EXEC;
            end
            S_MEM: begin
                if (w_is_wr) begin
                    wr_dmem  = 1'b1;
                    src_adr  = (opcode == c_op_stt);
                    src_data = (opcode == c_op_stt);
                end else begin
                    rd_dmem = 1'b1;
                    // LDI is the only indirect load: address comes from T.
                    src_adr = (opcode == c_op_ldi);
                end
                if (mem_ready) begin
                    w_state_next = S_EXEC;
                end else if (r_wait_cnt == c_wait_limit) begin
                    w_timeout    = 1'b1;
                    w_state_next = S_HALT;
                end
            end
            S_EXEC: begin
                w_state_next = S_FETCH;
                src_pc       = c_pc_inc;
                case (opcode)
                    c_op_adc: begin alu_op = 3'b000; wr_a = 1'b1; end
                    c_op_sbr: begin alu_op = 3'b001; wr_a = 1'b1; end
                    c_op_ror: begin alu_op = 3'b100; wr_a = 1'b1; end
                    c_op_xor: begin alu_op = 3'b101; wr_a = 1'b1; end
                    c_op_or:  begin alu_op = 3'b110; wr_a = 1'b1; end
                    c_op_and: begin alu_op = 3'b111; wr_a = 1'b1; end
                    c_op_ldc, c_op_lda, c_op_ldi: begin
                        wr_a  = 1'b1;
                        src_a = 1'b1;
                    end
                    c_op_tat: wr_t = 1'b1;
                    c_op_stt: begin src_adr = 1'b1; src_data = 1'b1; end
                    c_op_jmp: src_pc = c_pc_vec;
                    c_op_bcc: src_pc = carry ? c_pc_inc : c_pc_vec;
                    c_op_bne: src_pc = zero  ? c_pc_inc : c_pc_vec;
                    default: ;
                endcase
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign fault = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_toy_sequencer.sv
// ============================================================================
// Module   : tb_toy_sequencer
// Brief    : Directed self-checking bench for toy_sequencer (TIMEOUT = 4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_toy_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic [3:0] opcode;
    logic       mem_ready;
    logic       carry;
    logic       zero;
    logic       imem_rd;
    logic       ir_ld;
    logic [1:0] src_pc;
    logic [2:0] alu_op;
    logic       wr_t;
    logic       wr_a;
    logic       src_a;
    logic       wr_dmem;
    logic       rd_dmem;
    logic       src_adr;
    logic       src_data;
    logic       halted;
    logic       fault;

    int n_tests = 0;
    int n_fail  = 0;

    toy_sequencer #(.TIMEOUT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .opcode    (opcode),
        .mem_ready (mem_ready),
        .carry     (carry),
        .zero      (zero),
        .imem_rd   (imem_rd),
        .ir_ld     (ir_ld),
        .src_pc    (src_pc),
        .alu_op    (alu_op),
        .wr_t      (wr_t),
        .wr_a      (wr_a),
        .src_a     (src_a),
        .wr_dmem   (wr_dmem),
        .rd_dmem   (rd_dmem),
        .src_adr   (src_adr),
        .src_data  (src_data),
        .halted    (halted),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    // {imem_rd, ir_ld, src_pc, alu_op, wr_t, wr_a, src_a, wr_dmem, rd_dmem, src_adr, src_data, halted, fault}
    function automatic logic [15:0] ov(input logic imem, input logic ir, input logic [1:0] pc,
                                       input logic [2:0] alu, input logic wt, input logic wa,
                                       input logic sa, input logic wd, input logic rd,
                                       input logic adr, input logic dat, input logic h,
                                       input logic f);
        return {imem, ir, pc, alu, wt, wa, sa, wd, rd, adr, dat, h, f};
    endfunction

    logic [15:0] e_idle, e_fetch_rdy, e_fetch_wait, e_mem_rd, e_mem_stt;
    logic [15:0] e_exec_adc, e_exec_ror, e_exec_tat, e_exec_stt, e_exec_ld;
    logic [15:0] e_exec_inc, e_exec_vec, e_halt, e_fault;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [15:0] exp);
        logic [15:0] obs;
        #1;
        obs = {imem_rd, ir_ld, src_pc, alu_op, wr_t, wr_a, src_a,
               wr_dmem, rd_dmem, src_adr, src_data, halted, fault};
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Starts in FETCH with mem_ready=1; walks DECODE and EXEC, ends back in FETCH.
    task automatic nonmem(input string tag, input logic [3:0] op, input logic c,
                          input logic z, input logic [15:0] exp_exec);
        opcode = op;
        carry  = c;
        zero   = z;
        step(); chk({tag, "_decode"}, e_idle);
        step(); chk({tag, "_exec"}, exp_exec);
        step(); chk({tag, "_refetch"}, e_fetch_rdy);
    endtask

    initial begin
        e_idle       = ov(0, 0, 2'b10, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        e_fetch_rdy  = ov(1, 1, 2'b10, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        e_fetch_wait = ov(1, 0, 2'b10, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        e_mem_rd     = ov(0, 0, 2'b10, 3'b000, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        e_mem_stt    = ov(0, 0, 2'b10, 3'b000, 0, 0, 0, 1, 0, 1, 1, 0, 0);
        e_exec_adc   = ov(0, 0, 2'b00, 3'b000, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        e_exec_ror   = ov(0, 0, 2'b00, 3'b100, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        e_exec_tat   = ov(0, 0, 2'b00, 3'b000, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        e_exec_stt   = ov(0, 0, 2'b00, 3'b000, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        e_exec_ld    = ov(0, 0, 2'b00, 3'b000, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        e_exec_inc   = ov(0, 0, 2'b00, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        e_exec_vec   = ov(0, 0, 2'b01, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        e_halt       = ov(0, 0, 2'b10, 3'b000, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        e_fault      = ov(0, 0, 2'b10, 3'b000, 0, 0, 0, 0, 0, 0, 0, 1, 1);

        rst_n = 1'b0; run = 1'b0; opcode = 4'h0;
        mem_ready = 1'b0; carry = 1'b0; zero = 1'b0;
        step(); step();
        chk("reset", e_idle);
        rst_n = 1'b1;
        step(); chk("idle_no_run", e_idle);

        // ADC, zero-wait: FETCH, DECODE, MEM, EXEC
        run = 1'b1; mem_ready = 1'b1; opcode = 4'b0001;
        chk("idle_ready_ignored", e_idle);
        step(); chk("adc_fetch", e_fetch_rdy);
        run = 1'b0;
        step(); chk("adc_decode", e_idle);
        step(); chk("adc_mem", e_mem_rd);
        step(); chk("adc_exec", e_exec_adc);
        step(); chk("adc_refetch", e_fetch_rdy);

        nonmem("bcc_c0", 4'b1010, 1'b0, 1'b0, e_exec_vec);
        nonmem("bcc_c1", 4'b1010, 1'b1, 1'b0, e_exec_inc);
        nonmem("bne_z1", 4'b1011, 1'b0, 1'b1, e_exec_inc);
        nonmem("bne_z0", 4'b1011, 1'b1, 1'b0, e_exec_vec);
        nonmem("jmp",    4'b0000, 1'b1, 1'b1, e_exec_vec);
        nonmem("ror",    4'b0100, 1'b0, 1'b0, e_exec_ror);
        nonmem("tat",    4'b0101, 1'b0, 1'b0, e_exec_tat);

        // STT with three MEM wait cycles
        opcode = 4'b1101;
        step(); chk("stt_decode", e_idle);
        mem_ready = 1'b0;
        step(); chk("stt_mem1", e_mem_stt);
        step(); chk("stt_mem2", e_mem_stt);
        step(); chk("stt_mem3", e_mem_stt);
        mem_ready = 1'b1;
        chk("stt_mem4", e_mem_stt);
        step(); chk("stt_exec", e_exec_stt);
        step(); chk("stt_refetch", e_fetch_rdy);

        // LDC with zero wait, then LDA interrupted by reset in MEM
        opcode = 4'b1001;
        step(); chk("ldc_decode", e_idle);
        step(); chk("ldc_mem", e_mem_rd);
        step(); chk("ldc_exec", e_exec_ld);
        step(); chk("ldc_refetch", e_fetch_rdy);
        opcode = 4'b1110;
        step(); step(); chk("lda_mem", e_mem_rd);
        rst_n = 1'b0;
        step(); chk("reset_mid_mem", e_idle);
        rst_n = 1'b1;

        // HLT opcode
        run = 1'b1; opcode = 4'b0111;
        step(); chk("hlt_fetch", e_fetch_rdy);
        run = 1'b0;
        step(); chk("hlt_decode", e_idle);
        step(); chk("hlt_halt", e_halt);
        run = 1'b1; step(); run = 1'b0; step();
        chk("hlt_run_ignored", e_halt);
        rst_n = 1'b0;
        step(); chk("hlt_reset", e_idle);
        rst_n = 1'b1;

        // FETCH timeout after 4 wait cycles
        run = 1'b1; mem_ready = 1'b0;
        step(); chk("to_fetch1", e_fetch_wait);
        run = 1'b0;
        step(); step(); step(); chk("to_fetch4", e_fetch_wait);
        step(); chk("to_halt", e_fault);
        run = 1'b1; step(); step(); run = 1'b0;
        chk("to_run_ignored", e_fault);
        rst_n = 1'b0;
        step(); chk("to_reset", e_idle);
        rst_n = 1'b1;

        // ready arriving on the limit cycle wins over the timeout
        run = 1'b1; mem_ready = 1'b0;
        step(); run = 1'b0;
        step(); step(); step();
        mem_ready = 1'b1; opcode = 4'b0101;
        chk("limit_ready", e_fetch_rdy);
        step(); chk("limit_decode", e_idle);
        step(); chk("limit_exec", e_exec_tat);
        step(); chk("limit_refetch", e_fetch_rdy);

        // MEM timeout
        opcode = 4'b1001;
        step(); mem_ready = 1'b0;
        step(); chk("memto_mem1", e_mem_rd);
        step(); step(); step(); chk("memto_mem4", e_mem_rd);
        step(); chk("memto_halt", e_fault);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/toy_sequencer.md
# toy_sequencer

Multi-cycle control sequencer for the toy accumulator CPU. Steps each instruction through fetch, decode, optional data-memory access and execute, and drives the datapath control lines (src_pc, alu_op, wr_t, wr_a, src_a, wr_dmem, rd_dmem, src_adr, src_data) only in the cycles where they are valid. Handles variable-latency instruction and data memory through a ready handshake with a timeout. Sits between the IR/flag registers and the existing datapath, replacing the purely combinational opcode decode.

## Interface
- TIMEOUT, 15: maximum cycles to wait for mem_ready in FETCH or MEM before faulting (1..255).
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- run  input  1  leave IDLE and start fetching.
- opcode  input  4  IR[7:4]; valid from DECODE onward.
- mem_ready  input  1  instruction/data memory access complete this cycle.
- carry  input  1  ALU carry flag, sampled in EXEC.
- zero  input  1  accumulator-zero flag, sampled in EXEC.
- imem_rd  output  1  instruction fetch request.
- ir_ld  output  1  load IR from instruction memory.
- src_pc  output  2  00 = PC+1, 01 = vector, 10 = hold.
- alu_op  output  3  ALU operation select.
- wr_t, wr_a  output  1 each  write T / write A.
- src_a  output  1  A source: 0 = ALU, 1 = memory data.
- wr_dmem, rd_dmem  output  1 each  data memory write / read request.
- src_adr  output  1  address: 0 = instruction operand, 1 = T (indirect).
- src_data  output  1  store data: 0 = A, 1 = T.
- halted  output  1  in HALT.
- fault  output  1  HALT entered by timeout (sticky until reset).

## Operation
- States: IDLE, FETCH, DECODE, MEM, EXEC, HALT.
- IDLE: all outputs inactive; run=1 -> FETCH.
- FETCH: imem_rd=1. On mem_ready: ir_ld=1 same cycle, -> DECODE.
- DECODE: no outputs. 0111 -> HALT (fault=0). Memory ops -> MEM. Otherwise -> EXEC.
- Memory read ops: ADC 0001, XOR 0010, SBR 0011, OR 0110, AND 1000, LDC 1001, LDA 1110, LDI 1100. Memory write ops: STT 1101, STA 1111.
- MEM: hold rd_dmem=1 (read) or wr_dmem=1 (write) plus src_adr/src_data until mem_ready; then -> EXEC.
- EXEC, one cycle, then -> FETCH:
  - ADC alu_op=000, SBR 001, ROR 0100 100, XOR 101, OR 110, AND 111; each with wr_a=1, src_a=0.
  - LDC/LDA/LDI: wr_a=1, src_a=1.
  - TAT 0101: wr_t=1.
  - STT: src_adr=1, src_data=1. STA: src_adr=0, src_data=0.
  - JMP 0000: src_pc=01. BCC 1010: src_pc=01 if carry=0, else 00. BNE 1011: src_pc=01 if zero=0, else 00.
  - All other instructions: src_pc=00.
- Outside EXEC src_pc=10. All unused control outputs are driven 0, never x.
- HALT: halted=1, src_pc=10, all enables 0. Stays until reset; run is ignored.
- Timeout: wait counter clears on entry to FETCH/MEM and increments each cycle without mem_ready. If the count reaches TIMEOUT -> HALT, fault=1. mem_ready in the same cycle as the limit: ready wins.

## Timing
- Reset (rst_n=0 at clk edge): state IDLE, every output 0 except src_pc=10; halted=0, fault=0, counter 0. Reset mid-access drops the request on the next edge.
- Zero-wait latency: non-memory instruction 3 cycles (FETCH, DECODE, EXEC); memory instruction 4 cycles. Each memory wait cycle adds 1.
- mem_ready is sampled only in FETCH/MEM; it is ignored in other states.
- Write enables (wr_a, wr_t) pulse exactly 1 cycle per instruction. The flag-based branch decision uses flag values at the EXEC edge.
- run is level-sensitive in IDLE only.

## Test plan
- Reset, then run=1 with mem_ready tied 1 and opcode=0001 -> imem_rd in cycle 1, rd_dmem in cycle 3, wr_a=1/alu_op=000/src_a=0 in cycle 4, then FETCH again; src_pc=00 only in cycle 4.
- BCC with carry=0 -> EXEC src_pc=01. BCC with carry=1 -> src_pc=00. BNE with zero=1 -> 00. JMP -> 01. Each takes 3 cycles.
- STT, mem_ready delayed 3 cycles in MEM -> wr_dmem/src_adr/src_data=1 held 4 cycles, no wr_a/wr_t pulse.
- TIMEOUT=4, mem_ready held 0 in FETCH -> HALT after 4 cycles, halted=1, fault=1. run toggling has no effect; rst_n=0 clears both flags.
- Opcode 0111 -> DECODE -> HALT, halted=1, fault=0, all enables 0.
- rst_n asserted during MEM read -> next cycle IDLE with rd_dmem=0 and src_pc=10.
